// File: rtl/axi4lite_pkg.sv
// Shared widths, response codes and FSM state types for the AXI4-Lite register slave.
package axi4lite_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_t;

endpackage

// File: rtl/axi4lite_regfile.sv
// Register storage behind the AXI4-Lite slave: one write port and one registered read port.
// Out-of-range reads return zero.
module axi4lite_regfile #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_in_range,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Storage update and read sampling; a read in the same cycle as a write sees the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[rd_idx] : '0;
            end
        end
    end

endmodule

// File: rtl/axi4lite_slave.sv
// AXI4-Lite slave endpoint over a small register file, with independent write and read FSMs.
// Addresses are word indices; any set bit above the index range gives SLVERR.
module axi4lite_slave
    import axi4lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = axi4lite_pkg::AXI_ADDR_WIDTH,
    parameter int AXI_DATA_WIDTH = axi4lite_pkg::AXI_DATA_WIDTH,
    parameter int NUM_REGS       = 16
) (
    input  logic                      A_CLK,
    input  logic                      A_RSTn,
    input  logic                      AW_VALID,
    output logic                      AW_READY,
    input  logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
    input  logic                      W_VALID,
    output logic                      W_READY,
    input  logic [AXI_DATA_WIDTH-1:0] W_DATA,
    output logic                      B_VALID,
    input  logic                      B_READY,
    output logic [1:0]                B_RESP,
    input  logic                      AR_VALID,
    output logic                      AR_READY,
    input  logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
    output logic                      R_VALID,
    input  logic                      R_READY,
    output logic [AXI_DATA_WIDTH-1:0] R_DATA,
    output logic [1:0]                R_RESP
);

    localparam int IDX_W = $clog2(NUM_REGS);

    function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr >> IDX_W) == '0;
    endfunction

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic                      aw_got;
    logic                      w_got;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;

    logic                      aw_hs;
    logic                      w_hs;
    logic                      ar_hs;
    logic                      have_aw;
    logic                      have_w;
    logic                      wr_commit;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic                      wr_ok;

    // Handshake detection and selection of the address/data that complete the write this cycle.
    always_comb begin
        aw_hs     = (wr_state == W_IDLE) && AW_VALID && AW_READY;
        w_hs      = (wr_state == W_IDLE) && W_VALID && W_READY;
        have_aw   = aw_got || aw_hs;
        have_w    = w_got || w_hs;
        wr_commit = (wr_state == W_IDLE) && have_aw && have_w;
        wr_addr   = aw_hs ? AW_ADDR : aw_addr_q;
        wr_data   = w_hs ? W_DATA : w_data_q;
        wr_ok     = addr_in_range(wr_addr);
        ar_hs     = (rd_state == axi4lite_pkg::R_IDLE) && AR_VALID && AR_READY;
    end

    // Write FSM: collect AW and W in any order, then hold the response until B_READY.
    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            wr_state  <= W_IDLE;
            AW_READY  <= 1'b0;
            W_READY   <= 1'b0;
            B_VALID   <= 1'b0;
            B_RESP    <= RESP_OKAY;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= AW_ADDR;
                        aw_got    <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_q <= W_DATA;
                        w_got    <= 1'b1;
                    end
                    if (wr_commit) begin
                        wr_state <= W_RESP;
                        B_VALID  <= 1'b1;
                        B_RESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        AW_READY <= 1'b0;
                        W_READY  <= 1'b0;
                        aw_got   <= 1'b0;
                        w_got    <= 1'b0;
                    end else begin
                        AW_READY <= !have_aw;
                        W_READY  <= !have_w;
                    end
                end
                W_RESP: begin
                    if (B_READY) begin
                        wr_state <= W_IDLE;
                        B_VALID  <= 1'b0;
                        AW_READY <= 1'b1;
                        W_READY  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: accept an address, present data one cycle later and hold it until R_READY.
    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            rd_state <= axi4lite_pkg::R_IDLE;
            AR_READY <= 1'b0;
            R_VALID  <= 1'b0;
            R_RESP   <= RESP_OKAY;
        end else begin
            case (rd_state)
                axi4lite_pkg::R_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= axi4lite_pkg::R_VALID;
                        AR_READY <= 1'b0;
                        R_VALID  <= 1'b1;
                        R_RESP   <= addr_in_range(AR_ADDR) ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        AR_READY <= 1'b1;
                    end
                end
                axi4lite_pkg::R_VALID: begin
                    if (R_READY) begin
                        rd_state <= axi4lite_pkg::R_IDLE;
                        R_VALID  <= 1'b0;
                        AR_READY <= 1'b1;
                    end
                end
                default: rd_state <= axi4lite_pkg::R_IDLE;
            endcase
        end
    end

    axi4lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (AXI_DATA_WIDTH),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk         (A_CLK),
        .rst_n       (A_RSTn),
        .wr_en       (wr_commit && wr_ok),
        .wr_idx      (wr_addr[IDX_W-1:0]),
        .wr_data     (wr_data),
        .rd_en       (ar_hs),
        .rd_in_range (addr_in_range(AR_ADDR)),
        .rd_idx      (AR_ADDR[IDX_W-1:0]),
        .rd_data     (R_DATA)
    );

endmodule

// File: tb/tb_axi4lite_slave.sv
// Self-checking bench for axi4lite_slave: directed and randomized transactions checked
// against a plain array model of the register file.
module tb_axi4lite_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NREGS = 16;

    logic          A_CLK = 1'b0;
    logic          A_RSTn = 1'b0;
    logic          AW_VALID = 1'b0;
    logic          AW_READY;
    logic [AW-1:0] AW_ADDR = '0;
    logic          W_VALID = 1'b0;
    logic          W_READY;
    logic [DW-1:0] W_DATA = '0;
    logic          B_VALID;
    logic          B_READY = 1'b0;
    logic [1:0]    B_RESP;
    logic          AR_VALID = 1'b0;
    logic          AR_READY;
    logic [AW-1:0] AR_ADDR = '0;
    logic          R_VALID;
    logic          R_READY = 1'b0;
    logic [DW-1:0] R_DATA;
    logic [1:0]    R_RESP;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] ref_regs [NREGS];

    axi4lite_slave #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .NUM_REGS       (NREGS)
    ) dut (
        .A_CLK    (A_CLK),
        .A_RSTn   (A_RSTn),
        .AW_VALID (AW_VALID),
        .AW_READY (AW_READY),
        .AW_ADDR  (AW_ADDR),
        .W_VALID  (W_VALID),
        .W_READY  (W_READY),
        .W_DATA   (W_DATA),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY),
        .B_RESP   (B_RESP),
        .AR_VALID (AR_VALID),
        .AR_READY (AR_READY),
        .AR_ADDR  (AR_ADDR),
        .R_VALID  (R_VALID),
        .R_READY  (R_READY),
        .R_DATA   (R_DATA),
        .R_RESP   (R_RESP)
    );

    always #5 A_CLK = ~A_CLK;

    task automatic tick();
        @(posedge A_CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic in_range(input logic [AW-1:0] addr);
        return addr < NREGS;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
        return in_range(addr) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr);
        return in_range(addr) ? ref_regs[addr[3:0]] : '0;
    endfunction

    task automatic applyReset();
        A_RSTn = 1'b0;
        tick();
        A_RSTn = 1'b1;
        for (int i = 0; i < NREGS; i++) ref_regs[i] = '0;
    endtask

    // Full write: AW driven from aw_start, W from w_start (cycles), response held for hold cycles.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input int aw_start, input int w_start, input int hold);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_now, w_now;
        int cyc = 0;
        W_DATA = data;
        AW_ADDR = addr;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (cyc >= aw_start && !aw_done) AW_VALID = 1'b1;
            if (cyc >= w_start && !w_done) W_VALID = 1'b1;
            aw_now = AW_VALID && AW_READY;
            w_now = W_VALID && W_READY;
            tick();
            if (aw_now) begin aw_done = 1; AW_VALID = 1'b0; end
            if (w_now) begin w_done = 1; W_VALID = 1'b0; end
            if (w_done && !aw_done) checkOutput("w_ready_dropped", {31'b0, W_READY}, 0);
            if (aw_done && !w_done) checkOutput("aw_ready_dropped", {31'b0, AW_READY}, 0);
            cyc++;
        end
        AW_VALID = 1'b0;
        W_VALID = 1'b0;
        checkOutput("wr_handshake", {30'b0, aw_done, w_done}, 3);
        if (in_range(addr)) ref_regs[addr[3:0]] = data;
        checkOutput("b_valid", {31'b0, B_VALID}, 1);
        checkOutput("b_resp", {30'b0, B_RESP}, {30'b0, exp_resp(addr)});
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("b_valid_hold", {31'b0, B_VALID}, 1);
            checkOutput("b_resp_hold", {30'b0, B_RESP}, {30'b0, exp_resp(addr)});
            checkOutput("aw_ready_hold", {31'b0, AW_READY}, 0);
        end
        B_READY = 1'b1;
        tick();
        B_READY = 1'b0;
        checkOutput("b_valid_drop", {31'b0, B_VALID}, 0);
    endtask

    // Full read with hold cycles of R_READY backpressure.
    task automatic doRead(input logic [AW-1:0] addr, input int hold);
        bit done = 0;
        bit now;
        int cyc = 0;
        AR_ADDR = addr;
        AR_VALID = 1'b1;
        while (!done && cyc < 40) begin
            now = AR_VALID && AR_READY;
            tick();
            if (now) done = 1;
            cyc++;
        end
        AR_VALID = 1'b0;
        checkOutput("rd_handshake", {31'b0, done}, 1);
        checkOutput("r_valid", {31'b0, R_VALID}, 1);
        checkOutput("r_data", R_DATA, exp_read(addr));
        checkOutput("r_resp", {30'b0, R_RESP}, {30'b0, exp_resp(addr)});
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("r_valid_hold", {31'b0, R_VALID}, 1);
            checkOutput("r_data_hold", R_DATA, exp_read(addr));
            checkOutput("ar_ready_hold", {31'b0, AR_READY}, 0);
        end
        R_READY = 1'b1;
        tick();
        R_READY = 1'b0;
        checkOutput("r_valid_drop", {31'b0, R_VALID}, 0);
    endtask

    initial begin
        logic [DW-1:0] old_val;
        logic [AW-1:0] a;
        int lead;

        $display("[TB] start");
        tick();
        applyReset();
        A_RSTn = 1'b0;
        tick();
        checkOutput("rst_aw_ready", {31'b0, AW_READY}, 0);
        checkOutput("rst_ar_ready", {31'b0, AR_READY}, 0);
        checkOutput("rst_b_valid", {31'b0, B_VALID}, 0);
        checkOutput("rst_r_valid", {31'b0, R_VALID}, 0);
        checkOutput("rst_r_data", R_DATA, 0);
        A_RSTn = 1'b1;

        // Reset then read, single write, read-back.
        doRead(32'd1, 0);
        applyStimulus(32'd1, 32'd1, 0, 0, 2);
        doRead(32'd1, 0);

        // Split write with W two cycles ahead of AW, then read-back.
        applyStimulus(32'd3, 32'hA5A5_A5A5, 2, 0, 0);
        doRead(32'd3, 0);

        // Backpressure on both response channels.
        applyStimulus(32'd7, 32'h1234_5678, 0, 0, 5);
        doRead(32'd7, 5);

        // Out-of-range write and read.
        applyStimulus(NREGS, 32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus(32'h8000_0002, 32'hCAFE_F00D, 1, 0, 0);
        doRead(NREGS, 0);
        doRead(32'h4000_0003, 0);
        for (int i = 0; i < NREGS; i++) doRead(i, 0);

        // Simultaneous read and write to the same register returns the old value.
        old_val = ref_regs[7];
        AW_ADDR = 32'd7; W_DATA = 32'h0BAD_F00D; AR_ADDR = 32'd7;
        checkOutput("sim_ready", {29'b0, AW_READY, W_READY, AR_READY}, 7);
        AW_VALID = 1'b1; W_VALID = 1'b1; AR_VALID = 1'b1;
        tick();
        AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
        ref_regs[7] = 32'h0BAD_F00D;
        checkOutput("sim_b_valid", {31'b0, B_VALID}, 1);
        checkOutput("sim_r_valid", {31'b0, R_VALID}, 1);
        checkOutput("sim_r_data_old", R_DATA, old_val);
        B_READY = 1'b1; R_READY = 1'b1;
        tick();
        B_READY = 1'b0; R_READY = 1'b0;
        doRead(32'd7, 0);

        // Randomized mix of writes and reads, including out-of-range addresses.
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0010) : 32'($urandom_range(0, NREGS - 1));
            lead = $urandom_range(0, 4);
            if ($urandom_range(0, 1) == 1)
                applyStimulus(a, $urandom, (lead > 2) ? lead - 2 : 0, (lead < 2) ? 2 - lead : 0, $urandom_range(0, 3));
            else
                doRead(a, $urandom_range(0, 3));
        end

        // Reset during the write response clears everything.
        AW_ADDR = 32'd5; W_DATA = 32'h5555_AAAA;
        AW_VALID = 1'b1; W_VALID = 1'b1;
        tick();
        AW_VALID = 1'b0; W_VALID = 1'b0;
        checkOutput("pre_rst_b_valid", {31'b0, B_VALID}, 1);
        applyReset();
        checkOutput("mid_rst_b_valid", {31'b0, B_VALID}, 0);
        for (int i = 0; i < NREGS; i++) doRead(i, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
